// File: rtl/writeback_regfile_pkg.sv
// Shared definitions for the writeback stage and register file.
package writeback_regfile_pkg;

   localparam int unsigned REG_COUNT = 32;

   typedef logic [4:0] reg_idx_t;

   // funct3 encodings of the RV64 loads; 3'b111 is reserved and handled as ld.
   typedef enum logic [2:0] {
      LOAD_LB  = 3'b000,
      LOAD_LH  = 3'b001,
      LOAD_LW  = 3'b010,
      LOAD_LD  = 3'b011,
      LOAD_LBU = 3'b100,
      LOAD_LHU = 3'b101,
      LOAD_LWU = 3'b110,
      LOAD_RSV = 3'b111
   } load_funct3_e;

endpackage

// File: rtl/writeback_regfile_load_extend.sv
// Combinational load sign/zero extension selected by the load funct3.
module load_extend
   import writeback_regfile_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   // Extend the right-aligned slice chosen by funct3; reserved code acts as ld.
   always_comb begin
      data_out = data_in;
      case (funct3)
         LOAD_LB:  data_out = {{(WIDTH-8){data_in[7]}},   data_in[7:0]};
         LOAD_LH:  data_out = {{(WIDTH-16){data_in[15]}}, data_in[15:0]};
         LOAD_LW:  data_out = {{(WIDTH-32){data_in[31]}}, data_in[31:0]};
         LOAD_LBU: data_out = {{(WIDTH-8){1'b0}},         data_in[7:0]};
         LOAD_LHU: data_out = {{(WIDTH-16){1'b0}},        data_in[15:0]};
         LOAD_LWU: data_out = {{(WIDTH-32){1'b0}},        data_in[31:0]};
         default:  data_out = data_in;
      endcase
   end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage, 32-entry architectural register file and pending-write
// scoreboard. Optional macro WB_BYPASS_EN enables same-cycle write->read
// bypass and masks the in-progress write out of the hazard check.
module writeback_regfile
   import writeback_regfile_pkg::*;
#(
   parameter int unsigned BUS_DATA_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      inWbValid,
   input  logic                      inRegWrite,
   input  logic                      inMemOrReg,
   input  logic [2:0]                inLoadFunct3,
   input  logic [BUS_DATA_WIDTH-1:0] inAluResult,
   input  logic [BUS_DATA_WIDTH-1:0] inMemData,
   input  logic [4:0]                inDestRegister,
   input  logic [4:0]                inReadReg1,
   input  logic [4:0]                inReadReg2,
   output logic [BUS_DATA_WIDTH-1:0] outReadData1,
   output logic [BUS_DATA_WIDTH-1:0] outReadData2,
   input  logic                      inIssueValid,
   input  logic                      inIssueRegWrite,
   input  logic [4:0]                inIssueDest,
   output logic                      outHazard,
   output logic                      outWbValid,
   output logic [4:0]                outWbRegister,
   output logic [BUS_DATA_WIDTH-1:0] outWbData
);

   logic [BUS_DATA_WIDTH-1:0] regs_q [REG_COUNT];
   logic [BUS_DATA_WIDTH-1:0] regs_d [REG_COUNT];
   logic [REG_COUNT-1:0]      pending_q, pending_d;
   logic                      wb_valid_q, wb_valid_d;
   reg_idx_t                  wb_reg_q, wb_reg_d;
   logic [BUS_DATA_WIDTH-1:0] wb_data_q, wb_data_d;

   logic [BUS_DATA_WIDTH-1:0] load_data;
   logic [BUS_DATA_WIDTH-1:0] wb_data;
   logic                      wr_qual;
   reg_idx_t                  wr_idx;
   logic                      issue_set;
   logic [REG_COUNT-1:0]      pend_eff;

   load_extend #(.WIDTH(BUS_DATA_WIDTH)) u_load_extend (
      .funct3   (inLoadFunct3),
      .data_in  (inMemData),
      .data_out (load_data)
   );

   // Select writeback data and qualify the register write.
   always_comb begin
      wb_data   = inMemOrReg ? load_data : inAluResult;
      wr_idx    = inDestRegister;
      wr_qual   = inWbValid && inRegWrite && (wr_idx != '0);
      issue_set = inIssueValid && inIssueRegWrite && (inIssueDest != '0);
   end

   // Next state of the register array; x0 is never written.
   always_comb begin
      regs_d = regs_q;
      if (wr_qual) begin
         regs_d[wr_idx] = wb_data;
      end
   end

   // Scoreboard next state: clear on writeback, then set on issue so the
   // younger issue wins when both hit the same index.
   always_comb begin
      pending_d = pending_q;
      if (wr_qual) begin
         pending_d[wr_idx] = 1'b0;
      end
      if (issue_set) begin
         pending_d[inIssueDest] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Registered writeback report; data/register hold when no write occurs.
   always_comb begin
      wb_valid_d = wr_qual;
      wb_reg_d   = wb_reg_q;
      wb_data_d  = wb_data_q;
      if (wr_qual) begin
         wb_reg_d  = wr_idx;
         wb_data_d = wb_data;
      end
   end

   // Combinational read ports, optional bypass of the write in progress.
   always_comb begin
      outReadData1 = regs_q[inReadReg1];
      outReadData2 = regs_q[inReadReg2];
`ifdef WB_BYPASS_EN
      if (wr_qual && (inReadReg1 == wr_idx)) begin
         outReadData1 = wb_data;
      end
      if (wr_qual && (inReadReg2 == wr_idx)) begin
         outReadData2 = wb_data;
      end
`endif
      if (inReadReg1 == '0) begin
         outReadData1 = '0;
      end
      if (inReadReg2 == '0) begin
         outReadData2 = '0;
      end
   end

   // Hazard: any source or the issuing destination still awaiting writeback.
   always_comb begin
      pend_eff = pending_q;
`ifdef WB_BYPASS_EN
      if (wr_qual) begin
         pend_eff[wr_idx] = 1'b0;
      end
`endif
      outHazard = pend_eff[inReadReg1] | pend_eff[inReadReg2] | pend_eff[inIssueDest];
   end

   // State update; asynchronous reset drops any in-flight writeback.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= '0;
         end
         pending_q  <= '0;
         wb_valid_q <= 1'b0;
         wb_reg_q   <= '0;
         wb_data_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= regs_d[i];
         end
         pending_q  <= pending_d;
         wb_valid_q <= wb_valid_d;
         wb_reg_q   <= wb_reg_d;
         wb_data_q  <= wb_data_d;
      end
   end

   assign outWbValid    = wb_valid_q;
   assign outWbRegister = wb_reg_q;
   assign outWbData     = wb_data_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile; expectations follow WB_BYPASS_EN.
module tb_writeback_regfile;

   localparam int unsigned W = 64;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         inWbValid, inRegWrite, inMemOrReg;
   logic [2:0]   inLoadFunct3;
   logic [W-1:0] inAluResult, inMemData;
   logic [4:0]   inDestRegister, inReadReg1, inReadReg2;
   logic [W-1:0] outReadData1, outReadData2;
   logic         inIssueValid, inIssueRegWrite;
   logic [4:0]   inIssueDest;
   logic         outHazard, outWbValid;
   logic [4:0]   outWbRegister;
   logic [W-1:0] outWbData;

   int n_checks = 0;
   int n_errors = 0;

   writeback_regfile #(.BUS_DATA_WIDTH(W)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .inWbValid       (inWbValid),
      .inRegWrite      (inRegWrite),
      .inMemOrReg      (inMemOrReg),
      .inLoadFunct3    (inLoadFunct3),
      .inAluResult     (inAluResult),
      .inMemData       (inMemData),
      .inDestRegister  (inDestRegister),
      .inReadReg1      (inReadReg1),
      .inReadReg2      (inReadReg2),
      .outReadData1    (outReadData1),
      .outReadData2    (outReadData2),
      .inIssueValid    (inIssueValid),
      .inIssueRegWrite (inIssueRegWrite),
      .inIssueDest     (inIssueDest),
      .outHazard       (outHazard),
      .outWbValid      (outWbValid),
      .outWbRegister   (outWbRegister),
      .outWbData       (outWbData)
   );

   always #5 clk = ~clk;

   // Decode must never issue into a hazard.
   always @(posedge clk) begin
      if (reset_n && inIssueValid) begin
         assert (!outHazard) else $error("issue while outHazard high");
      end
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      inWbValid = 1'b0; inRegWrite = 1'b0; inMemOrReg = 1'b0; inLoadFunct3 = 3'd0;
      inAluResult = '0; inMemData = '0; inDestRegister = 5'd0;
      inIssueValid = 1'b0; inIssueRegWrite = 1'b0; inIssueDest = 5'd0;
   endtask

   task automatic set_wb(input logic [4:0] dest, input logic mem, input logic [2:0] f3,
                         input logic [W-1:0] alu, input logic [W-1:0] md);
      inWbValid = 1'b1; inRegWrite = 1'b1; inDestRegister = dest;
      inMemOrReg = mem; inLoadFunct3 = f3; inAluResult = alu; inMemData = md;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [2:0]   v_f3  [9];
   logic         v_mem [9];
   logic [W-1:0] v_in  [9];
   logic [W-1:0] v_exp [9];

   initial begin
      v_f3[0] = 3'b000; v_mem[0] = 1; v_in[0] = 64'h80;                  v_exp[0] = 64'hFFFF_FFFF_FFFF_FF80;
      v_f3[1] = 3'b100; v_mem[1] = 1; v_in[1] = 64'h80;                  v_exp[1] = 64'h80;
      v_f3[2] = 3'b110; v_mem[2] = 1; v_in[2] = 64'hFFFF_FFFF_8000_0000; v_exp[2] = 64'h8000_0000;
      v_f3[3] = 3'b001; v_mem[3] = 1; v_in[3] = 64'h1234_5678_9ABC_8001; v_exp[3] = 64'hFFFF_FFFF_FFFF_8001;
      v_f3[4] = 3'b101; v_mem[4] = 1; v_in[4] = 64'h1234_5678_9ABC_8001; v_exp[4] = 64'h8001;
      v_f3[5] = 3'b010; v_mem[5] = 1; v_in[5] = 64'h1234_5678_8765_4321; v_exp[5] = 64'hFFFF_FFFF_8765_4321;
      v_f3[6] = 3'b011; v_mem[6] = 1; v_in[6] = 64'h1234_5678_8765_4321; v_exp[6] = 64'h1234_5678_8765_4321;
      v_f3[7] = 3'b111; v_mem[7] = 1; v_in[7] = 64'hFEDC_BA98_7654_3210; v_exp[7] = 64'hFEDC_BA98_7654_3210;
      v_f3[8] = 3'b000; v_mem[8] = 0; v_in[8] = 64'hFF;                  v_exp[8] = 64'h0BAD_F00D;

      idle_inputs();
      inReadReg1 = 5'd0; inReadReg2 = 5'd0;
      reset_n = 1'b0;
      #1;
      check("rst_hazard", {63'd0, outHazard}, 64'd0);
      check("rst_wbvalid", {63'd0, outWbValid}, 64'd0);
      check("rst_wbreg", {59'd0, outWbRegister}, 64'd0);
      check("rst_wbdata", outWbData, 64'd0);
      tick(); tick();
      reset_n = 1'b1;
      #1;

      for (int i = 0; i < 32; i++) begin
         inReadReg1 = 5'(i);
         inReadReg2 = 5'(31 - i);
         #1;
         check($sformatf("rst_rd1_x%0d", i), outReadData1, 64'd0);
         check($sformatf("rst_rd2_x%0d", 31 - i), outReadData2, 64'd0);
         check("rst_hazard_rd", {63'd0, outHazard}, 64'd0);
      end

      // Load extension and ALU select, all into x5.
      for (int k = 0; k < 9; k++) begin
         inReadReg1 = 5'd0; inReadReg2 = 5'd0;
         set_wb(5'd5, v_mem[k], v_f3[k], (k == 8) ? 64'h0BAD_F00D : 64'h0, v_in[k]);
         tick();
         idle_inputs();
         check($sformatf("wbvalid_%0d", k), {63'd0, outWbValid}, 64'd1);
         check($sformatf("wbreg_%0d", k), {59'd0, outWbRegister}, 64'd5);
         check($sformatf("wbdata_%0d", k), outWbData, v_exp[k]);
         inReadReg1 = 5'd5; inReadReg2 = 5'd5;
         #1;
         check($sformatf("x5_rd1_%0d", k), outReadData1, v_exp[k]);
         check($sformatf("x5_rd2_%0d", k), outReadData2, v_exp[k]);
      end

      // x0 is never written.
      inReadReg1 = 5'd0; inReadReg2 = 5'd0;
      set_wb(5'd0, 1'b0, 3'd0, 64'h1234, 64'h0);
      #1;
      check("x0_rd_during", outReadData1, 64'd0);
      tick();
      idle_inputs();
      check("x0_wbvalid", {63'd0, outWbValid}, 64'd0);
      check("x0_rd_after", outReadData1, 64'd0);
      check("x0_hazard", {63'd0, outHazard}, 64'd0);

      // Write with inRegWrite low is ignored.
      set_wb(5'd6, 1'b0, 3'd0, 64'h66, 64'h0);
      inRegWrite = 1'b0;
      tick();
      idle_inputs();
      inReadReg1 = 5'd6;
      #1;
      check("nowr_wbvalid", {63'd0, outWbValid}, 64'd0);
      check("nowr_x6", outReadData1, 64'd0);

      // RAW on x7 through the scoreboard.
      inReadReg1 = 5'd0;
      inIssueValid = 1'b1; inIssueRegWrite = 1'b1; inIssueDest = 5'd7;
      #1;
      check("x7_issue_haz", {63'd0, outHazard}, 64'd0);
      tick();
      idle_inputs();
      inReadReg1 = 5'd7;
      #1;
      check("x7_pend_haz1", {63'd0, outHazard}, 64'd1);
      tick();
      check("x7_pend_haz2", {63'd0, outHazard}, 64'd1);
      set_wb(5'd7, 1'b0, 3'd0, 64'hDEAD, 64'h0);
      #1;
`ifdef WB_BYPASS_EN
      check("x7_wb_haz", {63'd0, outHazard}, 64'd0);
      check("x7_wb_rd", outReadData1, 64'hDEAD);
`else
      check("x7_wb_haz", {63'd0, outHazard}, 64'd1);
      check("x7_wb_rd", outReadData1, 64'd0);
`endif
      tick();
      idle_inputs();
      #1;
      check("x7_after_haz", {63'd0, outHazard}, 64'd0);
      check("x7_after_rd", outReadData1, 64'hDEAD);

      // Issue and writeback of x9 in the same cycle: set wins.
      inReadReg1 = 5'd0;
      set_wb(5'd9, 1'b0, 3'd0, 64'h99, 64'h0);
      inIssueValid = 1'b1; inIssueRegWrite = 1'b1; inIssueDest = 5'd9;
      #1;
      check("x9_same_haz", {63'd0, outHazard}, 64'd0);
      tick();
      idle_inputs();
      inReadReg2 = 5'd9;
      #1;
      check("x9_pend_haz", {63'd0, outHazard}, 64'd1);
      check("x9_rd", outReadData2, 64'h99);
      check("x9_wbreg", {59'd0, outWbRegister}, 64'd9);

      // Reset mid-stream with pending bits and a write in flight.
      inReadReg2 = 5'd0;
      inIssueValid = 1'b1; inIssueRegWrite = 1'b1; inIssueDest = 5'd3;
      tick();
      idle_inputs();
      set_wb(5'd12, 1'b0, 3'd0, 64'h55, 64'h0);
      inReadReg1 = 5'd3; inReadReg2 = 5'd9;
      #1;
      check("pre_rst_haz", {63'd0, outHazard}, 64'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_haz", {63'd0, outHazard}, 64'd0);
      check("mid_rst_wbvalid", {63'd0, outWbValid}, 64'd0);
      inReadReg1 = 5'd5;
      #1;
      check("mid_rst_x5", outReadData1, 64'd0);
      tick();
      idle_inputs();
      reset_n = 1'b1;
      inReadReg1 = 5'd3; inReadReg2 = 5'd9;
      #1;
      check("post_rst_haz", {63'd0, outHazard}, 64'd0);
      check("post_rst_x9", outReadData2, 64'd0);
      inReadReg1 = 5'd12;
      #1;
      check("post_rst_x12", outReadData1, 64'd0);
      tick();
      check("post_rst_wbvalid", {63'd0, outWbValid}, 64'd0);
      check("post_rst_x12b", outReadData1, 64'd0);

      // First write after release is accepted.
      set_wb(5'd12, 1'b0, 3'd0, 64'hABCD, 64'h0);
      tick();
      idle_inputs();
      check("rel_wbvalid", {63'd0, outWbValid}, 64'd1);
      check("rel_x12", outReadData1, 64'hABCD);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
